// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I load, store or fence_i against a single-cycle data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of forcing alignment.
module load_store_unit #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [1:0]        i_kind,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic              o_dm_ren,
    output logic              o_dm_wen,
    output logic [3:0]        o_dm_ben,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wdata,
    input  logic [31:0]       i_dm_rdata,
    output logic              o_fence_i,
    input  logic              i_mem_ready
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, FENCE_WAIT} state_t;

    localparam logic [1:0] K_LOAD  = 2'b00;
    localparam logic [1:0] K_STORE = 2'b01;
    localparam logic [1:0] K_FENCE = 2'b10;
    localparam logic [1:0] K_NOP   = 2'b11;

    state_t            state;
    logic [1:0]        kind_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              fw_second;
    logic [1:0]        ofs;
    logic [3:0]        ben;
    logic              issue;
    logic              f3_ok;
    logic              align_bad;
    logic              reject;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

    assign f3_ok  = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
    assign align_bad = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    assign align_bad = 1'b0;
`endif
    assign reject = ((i_kind == K_LOAD) || (i_kind == K_STORE)) && (!f3_ok || align_bad);

    // Lane offset with the low bits a halfword/word ignores forced to zero.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   ofs = addr_q[1:0];
            2'b01:   ofs = {addr_q[1], 1'b0};
            default: ofs = 2'b00;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   begin ben = 4'b0001 << ofs;                    o_dm_wdata = {4{wdata_q[7:0]}};  end
            2'b01:   begin ben = ofs[1] ? 4'b1100 : 4'b0011;        o_dm_wdata = {2{wdata_q[15:0]}}; end
            default: begin ben = 4'b1111;                           o_dm_wdata = wdata_q;            end
        endcase
    end

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {lo, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Strobes are combinational on i_mem_ready so a request issues in the very cycle memory is ready.
    assign issue      = (state == REQ) && i_mem_ready;
    assign o_dm_ren   = issue && (kind_q == K_LOAD);
    assign o_dm_wen   = issue && (kind_q == K_STORE);
    assign o_fence_i  = issue && (kind_q == K_FENCE);
    assign o_dm_ben   = (o_dm_ren || o_dm_wen) ? ben : 4'b0000;
    assign o_dm_addr  = addr_q[ADDR_W+1:2];
    assign o_busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_rdata      <= 32'h0;
            fw_second    <= 1'b0;
            kind_q       <= K_NOP;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            case (state)
                IDLE: if (i_valid) begin
                    kind_q  <= i_kind;
                    f3_q    <= i_funct3;
                    addr_q  <= i_addr[ADDR_W+1:0];
                    wdata_q <= i_wdata;
                    if (reject || i_kind == K_NOP) begin
                        o_done       <= 1'b1;
                        o_misaligned <= reject;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: if (i_mem_ready) begin
                    case (kind_q)
                        K_LOAD:  state <= RESP;
                        K_STORE: begin state <= IDLE; o_done <= 1'b1; end
                        K_FENCE: begin state <= FENCE_WAIT; fw_second <= 1'b0; end
                        default: state <= IDLE;
                    endcase
                end
                RESP: begin
                    o_rdata <= extract(f3_q, ofs, i_dm_rdata);
                    o_done  <= 1'b1;
                    state   <= IDLE;
                end
                FENCE_WAIT: begin
                    fw_second <= 1'b1;
                    if (fw_second && i_mem_ready) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected completions plus per-scenario strobe checks.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [1:0]  kind = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misaligned, dm_ren, dm_wen, fence_i;
    logic [31:0] rdata, dm_wdata;
    logic [3:0]  dm_ben;
    logic [13:0] dm_addr;
    logic [31:0] dm_rdata = 32'h0;
    logic        mem_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_rdata = 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int ren_n; int ren_c; int wen_n; int wen_c; int fen_n; int fen_c; int done_c;
        bit clash; logic [13:0] addr; logic [3:0] ben; logic [31:0] wdata; logic [31:0] rdata;
        logic mis; logic [31:0] busy;
    } obs_t;

    typedef struct { logic [31:0] rdata; logic mis; int lat; int nren; } exp_t;
    exp_t sb[$];

    load_store_unit #(.ADDR_W(14)) dut (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_kind(kind), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata),
        .o_misaligned(misaligned), .o_dm_ren(dm_ren), .o_dm_wen(dm_wen), .o_dm_ben(dm_ben),
        .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata),
        .o_fence_i(fence_i), .i_mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0] b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] f3, input logic [1:0] lo);
        return TRAP && (((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00)));
    endfunction

    // Cycle c=0 is the acceptance cycle; rdy[c] is i_mem_ready during cycle c.
    task automatic do_op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mw, input logic [31:0] rdy,
                         input bit imm, output obs_t o);
        logic prev_ren;
        o.ren_n = 0; o.ren_c = -1; o.wen_n = 0; o.wen_c = -1; o.fen_n = 0; o.fen_c = -1;
        o.done_c = -1; o.clash = 0; o.addr = '0; o.ben = '0; o.wdata = '0; o.rdata = '0;
        o.mis = 0; o.busy = '0;
        if (!imm) begin @(posedge clk); #1; end
        valid = 1'b1; kind = k; funct3 = f3; addr = a; wdata = wd; mem_ready = rdy[0];
        o.busy[0] = busy;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dm_ren) begin o.ren_n++; o.ren_c = c; o.addr = dm_addr; o.ben = dm_ben; end
            if (dm_wen) begin o.wen_n++; o.wen_c = c; o.addr = dm_addr; o.ben = dm_ben; o.wdata = dm_wdata; end
            if (fence_i) begin o.fen_n++; o.fen_c = c; end
            if ((dm_ren && dm_wen) || (fence_i && (dm_ren || dm_wen))) o.clash = 1;
            prev_ren = dm_ren;
            @(posedge clk); #1;
            valid = 1'b0;
            mem_ready = rdy[c+1];
            dm_rdata = prev_ren ? mw : $urandom;
            o.busy[c+1] = busy;
            if (done) begin
                o.done_c = c + 1; o.rdata = rdata; o.mis = misaligned;
                mem_ready = 1'b1;
                return;
            end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, rdata, misaligned, dm_ren, dm_wen, dm_ben, fence_i} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b rdata=%h mis=%b ren=%b wen=%b ben=%b fence=%b want all 0",
                     busy, done, rdata, misaligned, dm_ren, dm_wen, dm_ben, fence_i);
        end
        rst = 1'b0;
    endtask

    task automatic test_loads();
        obs_t o;
        exp_t e;
        logic [31:0] w;
        logic [2:0] f3;
        // lb from the top byte lane of word 1, sign bit set
        sb.push_back('{32'hFFFF_FF80, 1'b0, 3, 1});
        do_op(2'b00, 3'b000, 32'h7, 32'h0, 32'h80AB_CD12, '1, 0, o);
        e = sb.pop_front(); last_rdata = e.rdata;
        vectors++; if (o.done_c !== e.lat) begin miscompares++; $display("FAIL lb_done_cycle: got %0d want %0d", o.done_c, e.lat); end
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL lb_rdata: got %h want %h", o.rdata, e.rdata); end
        vectors++; if (o.ren_c !== 1 || o.ren_n !== 1 || o.addr !== 14'd1) begin miscompares++;
            $display("FAIL lb_ren: got cyc=%0d n=%0d addr=%0d want cyc=1 n=1 addr=1", o.ren_c, o.ren_n, o.addr); end
        // lhu with memory stalled for three REQ cycles
        sb.push_back('{32'h0000_8001, 1'b0, 6, 1});
        do_op(2'b00, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 32'hFFFF_FFF1, 0, o);
        e = sb.pop_front(); last_rdata = e.rdata;
        vectors++; if (o.done_c !== e.lat) begin miscompares++; $display("FAIL lhu_stall_done: got %0d want %0d", o.done_c, e.lat); end
        vectors++; if (o.ren_c !== 4 || o.ren_n !== 1) begin miscompares++; $display("FAIL lhu_stall_ren: got cyc=%0d n=%0d want cyc=4 n=1", o.ren_c, o.ren_n); end
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL lhu_stall_rdata: got %h want %h", o.rdata, e.rdata); end
        // every load width at every byte offset
        for (int i = 0; i < 5; i++) begin
            f3 = (i < 3) ? 3'(i) : 3'(i + 1);
            for (int j = 0; j < 4; j++) begin
                w = $urandom;
                if (model_bad(f3, 2'(j))) sb.push_back('{last_rdata, 1'b1, 1, 0});
                else sb.push_back('{model_load(f3, 2'(j), w), 1'b0, 3, 1});
                do_op(2'b00, f3, 32'h100 + 32'(j), 32'h0, w, '1, 0, o);
                e = sb.pop_front(); last_rdata = e.rdata;
                vectors++; if (o.done_c !== e.lat || o.mis !== e.mis || o.ren_n !== e.nren) begin miscompares++;
                    $display("FAIL load_f3_%0d_off%0d_ctl: got done=%0d mis=%b ren=%0d want done=%0d mis=%b ren=%0d",
                             f3, j, o.done_c, o.mis, o.ren_n, e.lat, e.mis, e.nren); end
                vectors++; if (o.rdata !== e.rdata) begin miscompares++;
                    $display("FAIL load_f3_%0d_off%0d_rdata: got %h want %h", f3, j, o.rdata, e.rdata); end
            end
        end
    endtask

    task automatic test_stores();
        obs_t o;
        logic [31:0] a [3] = '{32'h12, 32'h3, 32'h8};
        logic [31:0] d [3] = '{32'h1234_BEEF, 32'h0000_00A5, 32'hCAFE_F00D};
        logic [2:0]  f [3] = '{3'b001, 3'b000, 3'b010};
        logic [3:0]  eb [3] = '{4'b1100, 4'b1000, 4'b1111};
        logic [31:0] ed [3] = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{last_rdata, 1'b0, 2, 0});
            do_op(2'b01, f[i], a[i], d[i], 32'h0, '1, 0, o);
            begin
                exp_t e;
                e = sb.pop_front();
                vectors++; if (o.done_c !== e.lat || o.mis !== e.mis || o.ren_n !== 0) begin miscompares++;
                    $display("FAIL store%0d_ctl: got done=%0d mis=%b ren=%0d want done=%0d mis=0 ren=0", i, o.done_c, o.mis, o.ren_n, e.lat); end
                vectors++; if (o.wen_c !== 1 || o.wen_n !== 1 || o.addr !== a[i][15:2]) begin miscompares++;
                    $display("FAIL store%0d_wen: got cyc=%0d n=%0d addr=%0d want cyc=1 n=1 addr=%0d", i, o.wen_c, o.wen_n, o.addr, a[i][15:2]); end
                vectors++; if (o.ben !== eb[i] || o.wdata !== ed[i]) begin miscompares++;
                    $display("FAIL store%0d_lanes: got ben=%b wdata=%h want ben=%b wdata=%h", i, o.ben, o.wdata, eb[i], ed[i]); end
                vectors++; if (rdata !== e.rdata) begin miscompares++;
                    $display("FAIL store%0d_rdata_hold: got %h want %h", i, rdata, e.rdata); end
            end
        end
    endtask

    task automatic test_fence();
        obs_t o;
        // memory drops ready in cycles 2..5 after acceptance
        do_op(2'b10, 3'b000, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFC3, 0, o);
        vectors++; if (o.done_c !== 7 || o.fen_c !== 1 || o.fen_n !== 1) begin miscompares++;
            $display("FAIL fence_stall: got done=%0d fence_cyc=%0d n=%0d want done=7 cyc=1 n=1", o.done_c, o.fen_c, o.fen_n); end
        vectors++; if (o.busy[7:0] !== 8'b0111_1110) begin miscompares++;
            $display("FAIL fence_busy: got %b want 01111110", o.busy[7:0]); end
        vectors++; if (o.ren_n !== 0 || o.wen_n !== 0 || o.clash || rdata !== last_rdata) begin miscompares++;
            $display("FAIL fence_side_effects: got ren=%0d wen=%0d clash=%b rdata=%h want 0 0 0 %h", o.ren_n, o.wen_n, o.clash, rdata, last_rdata); end
        do_op(2'b10, 3'b000, 32'h0, 32'h0, 32'h0, '1, 0, o);
        vectors++; if (o.done_c !== 4) begin miscompares++; $display("FAIL fence_min_wait: got %0d want 4", o.done_c); end
    endtask

    task automatic test_invalid();
        obs_t o;
        logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            do_op(2'(i & 1), bad[i], 32'h40, 32'hFFFF_FFFF, 32'h0, '1, 0, o);
            vectors++; if (o.done_c !== 1 || o.mis !== 1'b1 || o.ren_n !== 0 || o.wen_n !== 0) begin miscompares++;
                $display("FAIL bad_funct3_%0d: got done=%0d mis=%b ren=%0d wen=%0d want 1 1 0 0", bad[i], o.done_c, o.mis, o.ren_n, o.wen_n); end
        end
        do_op(2'b11, 3'b010, 32'h40, 32'h0, 32'h0, '1, 0, o);
        vectors++; if (o.done_c !== 1 || o.mis !== 1'b0 || o.ren_n + o.wen_n + o.fen_n !== 0) begin miscompares++;
            $display("FAIL kind_nop: got done=%0d mis=%b accesses=%0d want 1 0 0", o.done_c, o.mis, o.ren_n + o.wen_n + o.fen_n); end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_op(2'b00, 3'b010, 32'h6, 32'h0, 32'h1357_9BDF, '1, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (o.done_c !== 1 || o.mis !== 1'b1 || o.ren_n !== 0) begin miscompares++;
            $display("FAIL lw_misaligned_trap: got done=%0d mis=%b ren=%0d want 1 1 0", o.done_c, o.mis, o.ren_n); end
`else
        vectors++; if (o.done_c !== 3 || o.mis !== 1'b0 || o.ren_c !== 1 || o.addr !== 14'd1 || o.rdata !== 32'h1357_9BDF) begin miscompares++;
            $display("FAIL lw_misaligned_forced: got done=%0d mis=%b ren_cyc=%0d addr=%0d rdata=%h want 3 0 1 1 13579bdf",
                     o.done_c, o.mis, o.ren_c, o.addr, o.rdata); end
        last_rdata = 32'h1357_9BDF;
`endif
    endtask

    task automatic test_back_to_back();
        obs_t o;
        do_op(2'b01, 3'b010, 32'h20, 32'h1111_2222, 32'h0, '1, 0, o);
        // next request is driven in the completion cycle of the store
        do_op(2'b00, 3'b100, 32'h21, 32'h0, 32'h0000_F700, '1, 1, o);
        vectors++; if (o.done_c !== 3 || o.rdata !== 32'h0000_00F7 || o.ren_c !== 1) begin miscompares++;
            $display("FAIL back_to_back_load: got done=%0d rdata=%h ren_cyc=%0d want 3 000000f7 1", o.done_c, o.rdata, o.ren_c); end
        last_rdata = 32'h0000_00F7;
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL done_single_pulse: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        int extra_done = 0;
        @(posedge clk); #1;
        valid = 1'b1; kind = 2'b00; funct3 = 3'b010; addr = 32'h30; mem_ready = 1'b1;
        @(posedge clk); #1; valid = 1'b0;
        @(posedge clk); #1;
        dm_rdata = 32'hFFFF_FFFF;
        rst = 1'b1; valid = 1'b1; kind = 2'b01;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0;
        vectors++;
        if ({busy, done, rdata, misaligned, dm_ren, dm_wen, dm_ben, fence_i} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_abort_outputs: got busy=%b done=%b rdata=%h mis=%b ren=%b wen=%b ben=%b fence=%b want all 0",
                     busy, done, rdata, misaligned, dm_ren, dm_wen, dm_ben, fence_i);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        vectors++; if (extra_done !== 0) begin miscompares++; $display("FAIL reset_abort_quiet: got %0d active cycles want 0", extra_done); end
        do_op(2'b00, 3'b001, 32'h32, 32'h0, 32'h8765_4321, '1, 0, o);
        vectors++; if (o.done_c !== 3 || o.rdata !== 32'hFFFF_8765) begin miscompares++;
            $display("FAIL after_reset_load: got done=%0d rdata=%h want 3 ffff8765", o.done_c, o.rdata); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_fence();
        test_invalid();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
